mmr_access_arbiter: RTL
=======================

Name: mmr_access_arbiter

Overview:
- Sequences and shares a bank of NUM_REGS 32-bit memory-mapped registers between two requesters: the HPS bridge port (hps_*) and the FPGA fabric port (fab_*).
- Arbitrates with round-robin priority, decodes the address, and drives one-hot write enables and a shared write-data bus to the external register instances.
- Returns read data from the flattened register outputs with an ack/err response.
- Sits between the HPS bridge slave logic and the register bank.

Parameters:
- NUM_REGS, 4, number of registers in the bank (1..2**ADDR_W).
- ADDR_W, 3, register address width; addresses >= NUM_REGS are out of range.
- DATA_W, 32, register and data-bus width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hps_req  input  1  HPS access request; held high until hps_ack.
- hps_we  input  1  HPS write (1) / read (0); stable while hps_req is high.
- hps_addr  input  ADDR_W  HPS register index; stable while hps_req is high.
- hps_wdata  input  DATA_W  HPS write data; stable while hps_req is high.
- hps_ack  output  1  one-cycle completion pulse.
- hps_err  output  1  valid with hps_ack; 1 = address out of range.
- hps_rdata  output  DATA_W  valid with hps_ack.
- fab_req, fab_we, fab_addr, fab_wdata, fab_ack, fab_err, fab_rdata  same as hps_* for the fabric port.
- reg_we  output  NUM_REGS  one-hot write enable, one per register.
- reg_wdata  output  DATA_W  shared write data to all registers.
- reg_rdata_flat  input  NUM_REGS*DATA_W  register outputs; register i occupies bits [i*DATA_W +: DATA_W].
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0; last_grant=FAB, so HPS wins the first contention. Asserting reset mid-transaction aborts it: no ack is issued and reg_we drops immediately.
- All outputs are registered.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Exactly one transaction is in flight at a time.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not last_grant.
  - On a grant, capture sel, we, addr and wdata; compute in_range = (addr < NUM_REGS); go to ACCESS.
  - If neither req is high, stay in IDLE.
- ACCESS (1 cycle):
  - reg_wdata = captured wdata.
  - reg_we[addr] = 1 only if we && in_range; otherwise reg_we = 0.
  - Go to RESP.
- RESP (1 cycle):
  - Pulse the selected port's ack.
  - err = !in_range.
  - rdata = reg_rdata_flat slice[addr] if in_range, else 0. For a write, this is the newly written value (read-after-write).
  - Update last_grant = sel; go to IDLE.
- The other port's ack, err and rdata stay 0 throughout. rdata returns to 0 when ack is low.
- Latency: request sampled in IDLE at cycle N; write enable at N+1; ack at N+2. Back-to-back throughput is one transaction per 3 cycles.
- Requester protocol: drop req on the edge after observing ack. A req still high in the IDLE cycle after ack is treated as a new transaction.
- reg_wdata holds its last value outside ACCESS. reg_we is never multi-hot.
- A request arriving while busy waits. Loser fairness: with both ports requesting continuously, grants strictly alternate.
- Out-of-range access: no reg_we pulse, err=1, rdata=0; last_grant still updates.
- Changing the request fields while req is high is a protocol violation; the fields captured in IDLE are used.

Test Plan:
- Reset: hold rst_n=0, drive both reqs -> all outputs 0, busy=0; release reset -> HPS is granted first.
- Single HPS write: addr=2, wdata=32'hDEADBEEF -> reg_we=4'b0100 for one cycle at N+1; hps_ack=1, err=0, hps_rdata=32'hDEADBEEF at N+2; fab_ack stays 0.
- Fabric read: addr=1 with reg 1 = 32'h12345678 -> fab_ack at N+2, fab_rdata=32'h12345678, reg_we=0 throughout.
- Contention: both reqs held continuously with fresh transactions for 4 rounds -> grant order HPS, FAB, HPS, FAB; each ack spaced 3 cycles apart.
- Out of range: HPS write addr=5 (NUM_REGS=4) -> no reg_we bit set; hps_ack=1, hps_err=1, hps_rdata=0.
- Reset mid-transaction: pull rst_n low during ACCESS of a write to addr=0 -> reg_we drops immediately, no ack; after release, FSM is in IDLE and accepts a new request normally.

Source files
------------

// File: rtl/mmr_access_arbiter.sv
// mmr_access_arbiter
// Shares a bank of NUM_REGS memory-mapped registers between the HPS bridge
// port and the FPGA fabric port. Each transaction takes three cycles:
// IDLE (grant and capture), ACCESS (write enable), RESP (ack/err/rdata).
// Round-robin arbitration gives the port that was not granted last the win
// when both request in the same cycle. All outputs come from flops.

module mmr_access_arbiter #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         hps_req,
  input  logic                         hps_we,
  input  logic [ADDR_W-1:0]            hps_addr,
  input  logic [DATA_W-1:0]            hps_wdata,
  output logic                         hps_ack,
  output logic                         hps_err,
  output logic [DATA_W-1:0]            hps_rdata,
  input  logic                         fab_req,
  input  logic                         fab_we,
  input  logic [ADDR_W-1:0]            fab_addr,
  input  logic [DATA_W-1:0]            fab_wdata,
  output logic                         fab_ack,
  output logic                         fab_err,
  output logic [DATA_W-1:0]            fab_rdata,
  output logic [NUM_REGS-1:0]          reg_we,
  output logic [DATA_W-1:0]            reg_wdata,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_rdata_flat,
  output logic                         busy
);

  localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // One-hot write-enable vector for a register index (all zero when no match).
  function automatic logic [NUM_REGS-1:0] decode_onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] vec;
    vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      vec[i] = (addr == ADDR_W'(i));
    end
    return vec;
  endfunction

  // Picks register word 'addr' out of the flattened read bus.
  function automatic logic [DATA_W-1:0] select_word(input logic [NUM_REGS*DATA_W-1:0] flat,
                                                     input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] word;
    word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      word = (addr == ADDR_W'(i)) ? flat[i*DATA_W +: DATA_W] : word;
    end
    return word;
  endfunction

  state_t                state_r, state_s;
  logic                  sel_r;          // 1 = fabric owns the transaction
  logic                  we_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic                  in_range_r;
  logic                  last_grant_r;   // 1 = fabric was granted last
  logic                  last_grant_s;

  logic                  grant_s;
  logic                  grant_fab_s;
  logic                  req_we_s;
  logic [ADDR_W-1:0]     req_addr_s;
  logic [DATA_W-1:0]     req_wdata_s;
  logic                  req_in_range_s;

  logic [NUM_REGS-1:0]   reg_we_r, reg_we_s;
  logic [DATA_W-1:0]     reg_wdata_r, reg_wdata_s;
  logic                  hps_ack_r, hps_ack_s, hps_err_r, hps_err_s;
  logic [DATA_W-1:0]     hps_rdata_r, hps_rdata_s;
  logic                  fab_ack_r, fab_ack_s, fab_err_r, fab_err_s;
  logic [DATA_W-1:0]     fab_rdata_r, fab_rdata_s;
  logic                  busy_r, busy_s;
  logic [DATA_W-1:0]     resp_data_s;

  // Round-robin winner and the winning port's request fields.
  always_comb begin
    grant_s        = hps_req | fab_req;
    grant_fab_s    = fab_req & (~hps_req | ~last_grant_r);
    req_we_s       = grant_fab_s ? fab_we    : hps_we;
    req_addr_s     = grant_fab_s ? fab_addr  : hps_addr;
    req_wdata_s    = grant_fab_s ? fab_wdata : hps_wdata;
    req_in_range_s = ({1'b0, req_addr_s} < NUM_REGS_C);
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    reg_we_s     = '0;
    reg_wdata_s  = reg_wdata_r;
    hps_ack_s    = 1'b0;
    hps_err_s    = 1'b0;
    hps_rdata_s  = '0;
    fab_ack_s    = 1'b0;
    fab_err_s    = 1'b0;
    fab_rdata_s  = '0;
    // The bank latches reg_we at the same edge that launches the response,
    // so a write returns its own data: that is what the register will hold.
    resp_data_s  = in_range_r ? (we_r ? wdata_r : select_word(reg_rdata_flat, addr_r)) : '0;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s     = ST_ACCESS;
          reg_wdata_s = req_wdata_s;
          if (req_we_s && req_in_range_s) begin
            reg_we_s = decode_onehot(req_addr_s);
          end else begin
            reg_we_s = '0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_s = ST_RESP;
        if (sel_r) begin
          fab_ack_s   = 1'b1;
          fab_err_s   = ~in_range_r;
          fab_rdata_s = resp_data_s;
        end else begin
          hps_ack_s   = 1'b1;
          hps_err_s   = ~in_range_r;
          hps_rdata_s = resp_data_s;
        end
      end
      ST_RESP: begin
        state_s      = ST_IDLE;
        last_grant_s = sel_r;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // FSM state, round-robin history and the captured request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      sel_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      in_range_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      if (state_r == ST_IDLE && grant_s) begin
        sel_r      <= grant_fab_s;
        we_r       <= req_we_s;
        addr_r     <= req_addr_s;
        wdata_r    <= req_wdata_s;
        in_range_r <= req_in_range_s;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we_r    <= '0;
      reg_wdata_r <= '0;
      hps_ack_r   <= 1'b0;
      hps_err_r   <= 1'b0;
      hps_rdata_r <= '0;
      fab_ack_r   <= 1'b0;
      fab_err_r   <= 1'b0;
      fab_rdata_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      reg_we_r    <= reg_we_s;
      reg_wdata_r <= reg_wdata_s;
      hps_ack_r   <= hps_ack_s;
      hps_err_r   <= hps_err_s;
      hps_rdata_r <= hps_rdata_s;
      fab_ack_r   <= fab_ack_s;
      fab_err_r   <= fab_err_s;
      fab_rdata_r <= fab_rdata_s;
      busy_r      <= busy_s;
    end
  end

  assign reg_we    = reg_we_r;
  assign reg_wdata = reg_wdata_r;
  assign hps_ack   = hps_ack_r;
  assign hps_err   = hps_err_r;
  assign hps_rdata = hps_rdata_r;
  assign fab_ack   = fab_ack_r;
  assign fab_err   = fab_err_r;
  assign fab_rdata = fab_rdata_r;
  assign busy      = busy_r;

endmodule
